apb_slv_memory_reg: RTL and testbench
=====================================

APB_SLV_MEMORY_REG -- requirements
Module: apb_slv_memory_reg

Interface
REQ-001 DATA_SIZE, 32, data bus width in bits; SHALL be a multiple of 8.
REQ-002 ADDR_SIZE, 6, word-address width; memory depth SHALL be 2**ADDR_SIZE words.
REQ-003 PCLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 PRESETn  input  1  reset; asynchronous and active-high (asserted when 1), despite the port name.
REQ-005 PADDR  input  ADDR_SIZE  word address; each value SHALL select one DATA_SIZE-bit word, with no byte-offset bits.
REQ-006 PSEL  input  1  slave select.
REQ-007 PENABLE  input  1  access-phase indicator.
REQ-008 PWRITE  input  1  1 = write, 0 = read.
REQ-009 PWDATA  input  DATA_SIZE  write data.
REQ-010 PSTROBE  input  DATA_SIZE/8  byte-lane write enables; bit n SHALL control PWDATA[8n+7:8n].
REQ-011 PREADY  output  1  transfer-complete indicator.
REQ-012 PRDATA  output  DATA_SIZE  read data.
REQ-013 PSLVERR  output  1  transfer error.

Function
REQ-014 SHALL contain a 2**ADDR_SIZE x DATA_SIZE register array.
REQ-015 SHALL implement a three-state FSM: IDLE=2'b00, W_ENABLE=2'b01, R_ENABLE=2'b10.
REQ-016 IDLE: when PSEL=1 and PENABLE=0 (setup phase), the next state SHALL be W_ENABLE if PWRITE=1, else R_ENABLE.
REQ-017 IDLE: all other input combinations SHALL keep the FSM in IDLE.
REQ-018 W_ENABLE/R_ENABLE: when PSEL=1 and PENABLE=1 (access phase), the access SHALL complete on that rising edge and the next state SHALL be IDLE.
REQ-019 W_ENABLE/R_ENABLE with PSEL=0: the transfer SHALL be aborted and the next state SHALL be IDLE, with no memory write.
REQ-020 W_ENABLE/R_ENABLE with PSEL=1 and PENABLE=0: the FSM SHALL hold its state.
REQ-021 PREADY SHALL be combinational: 1 when state is W_ENABLE or R_ENABLE and PSEL=PENABLE=1, else 0.
REQ-022 Transfers SHALL have zero wait states.
REQ-023 Write: on the access-phase edge, each byte n of mem[PADDR] with PSTROBE[n]=1 SHALL take PWDATA byte n.
REQ-024 Write: bytes with PSTROBE[n]=0 SHALL retain their value.
REQ-025 Read: on the setup-phase edge (IDLE to R_ENABLE), PRDATA SHALL be registered with mem[PADDR] and be valid throughout the access phase.
REQ-026 PRDATA SHALL hold its last value at all other times.
REQ-027 PSTROBE SHALL be ignored for reads.
REQ-028 PSLVERR SHALL be combinational: 1 only during a write access phase (state W_ENABLE, PSEL=PENABLE=1) with PSTROBE all zero, else 0.
REQ-029 An erroring write SHALL leave memory unchanged and still complete with PREADY=1.
REQ-030 Back-to-back transfers (PSEL held high, PENABLE dropped after access) SHALL be accepted as a new setup phase from IDLE.
REQ-031 Every PADDR value SHALL be in range.
REQ-032 A write followed by a read of the same address SHALL return the newly written data.

Reset
REQ-033 While PRESETn=1, asynchronously: state SHALL be IDLE, all memory words SHALL be 0, PRDATA SHALL be 0, PREADY SHALL be 0 and PSLVERR SHALL be 0.
REQ-034 Reset asserted mid-transfer SHALL abort the transfer with no partial write.
REQ-035 After reset deasserts, the first rising edge SHALL accept a setup phase.

Verification
REQ-036 Reset: PRESETn=1 -> PRDATA=0, PREADY=0, PSLVERR=0, and a read of any address returns 0.
REQ-037 Byte strobes: write 0x55555555 with PSTROBE 4'h4 to addr 0, 4'h3 to addr 1, 4'h2 to addr 2, 4'h1 to addr 3 and 4'hF to addr 5 -> reads return 0x00550000, 0x00005555, 0x00005500, 0x00000055 and 0x55555555 respectively.
REQ-038 Zero strobe: write addr 4 with PSTROBE=0 -> PSLVERR=1 and PREADY=1 in the access phase, and addr 4 still reads 0.
REQ-039 Sweep: write addr i with data i for i = 0..63, PSTROBE=4'hF, then read all -> each read returns i, with PREADY=1 for exactly one cycle per transfer.
REQ-040 Abort: setup a write to addr 7, then drop PSEL before PENABLE -> FSM returns to IDLE and addr 7 is unchanged.
REQ-041 Mid-transfer reset: assert PRESETn during a write access phase -> memory is all zeros and the FSM is IDLE.

Source files
------------

// File: rtl/apb_slv_memory_reg.sv
// APB slave backed by a 2**ADDR_SIZE x DATA_SIZE register array.
// Zero-wait-state transfers, byte-lane write strobes, registered read data.
// PRESETn is an asynchronous, active-high reset despite its name.
module apb_slv_memory_reg #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 6
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic [ADDR_SIZE-1:0]   PADDR,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic                   PWRITE,
  input  logic [DATA_SIZE-1:0]   PWDATA,
  input  logic [DATA_SIZE/8-1:0] PSTROBE,
  output logic                   PREADY,
  output logic [DATA_SIZE-1:0]   PRDATA,
  output logic                   PSLVERR
);

  localparam int DEPTH  = 2 ** ADDR_SIZE;
  localparam int NBYTES = DATA_SIZE / 8;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    W_ENABLE = 2'b01,
    R_ENABLE = 2'b10
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [DATA_SIZE-1:0]   prdata_q;
  logic [DATA_SIZE-1:0]   rd_words [DEPTH];

  logic setup_phase;
  logic access_phase;
  logic wr_en;
  logic rd_load;

  // Setup phase is only meaningful from IDLE; access phase only from an ENABLE state.
  assign setup_phase  = (state_q == IDLE) && PSEL && !PENABLE;
  assign access_phase = ((state_q == W_ENABLE) || (state_q == R_ENABLE)) && PSEL && PENABLE;

  // A write with no byte lanes enabled is flagged as an error and leaves memory alone.
  assign wr_en   = (state_q == W_ENABLE) && PSEL && PENABLE && (|PSTROBE);
  assign rd_load = setup_phase && !PWRITE;

  assign PREADY  = access_phase;
  assign PSLVERR = (state_q == W_ENABLE) && PSEL && PENABLE && (PSTROBE == '0);
  assign PRDATA  = prdata_q;

  // State register.
  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic: setup moves to an ENABLE state, access or deselect returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) state_d = PWRITE ? W_ENABLE : R_ENABLE;
        else                  state_d = IDLE;
      end
      W_ENABLE, R_ENABLE: begin
        if (!PSEL)        state_d = IDLE;
        else if (PENABLE) state_d = IDLE;
        else              state_d = state_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data is captured at the setup edge so it is stable for the whole access phase.
  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn)      prdata_q <= '0;
    else if (rd_load) prdata_q <= rd_words[PADDR];
  end

  // Storage: one byte register per lane per word, each written only when its strobe is set.
  for (genvar w = 0; w < DEPTH; w++) begin : g_word
    logic                 word_sel;
    logic [DATA_SIZE-1:0] word_val;

    assign word_sel = wr_en && (PADDR == ADDR_SIZE'(w));

    for (genvar b = 0; b < NBYTES; b++) begin : g_byte
      logic [7:0] byte_q;

      // Byte lane register; cleared asynchronously by reset.
      always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn)                    byte_q <= '0;
        else if (word_sel && PSTROBE[b]) byte_q <= PWDATA[8*b +: 8];
      end

      assign word_val[8*b +: 8] = byte_q;
    end

    assign rd_words[w] = word_val;
  end

endmodule

// File: tb/tb_apb_slv_memory_reg.sv
// Directed testbench for apb_slv_memory_reg: reset, byte strobes, zero-strobe
// error, abort, full address sweep with back-to-back transfers, mid-transfer reset.
module tb_apb_slv_memory_reg;

  logic        PCLK;
  logic        PRESETn;
  logic [5:0]  PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTROBE;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  int n_checks;
  int n_errors;

  apb_slv_memory_reg #(.DATA_SIZE(32), .ADDR_SIZE(6)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PADDR   (PADDR),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
    .PSTROBE (PSTROBE),
    .PREADY  (PREADY),
    .PRDATA  (PRDATA),
    .PSLVERR (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the access edge with the bus released.
  task automatic apb_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic rdy_setup, output logic rdy_acc, output logic err_acc);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = addr; PWDATA = data; PSTROBE = strb;
    @(negedge PCLK);
    rdy_setup = PREADY;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    rdy_acc = PREADY;
    err_acc = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic apb_read(input logic [5:0] addr,
                          output logic [31:0] data, output logic rdy_setup, output logic rdy_acc);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = addr; PSTROBE = 4'h0;
    @(negedge PCLK);
    rdy_setup = PREADY;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    rdy_acc = PREADY;
    data    = PRDATA;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    logic        rs, ra, er;
    logic [31:0] rd;
    logic [5:0]  strb_addr [5];
    logic [3:0]  strb_val  [5];
    logic [31:0] strb_exp  [5];

    n_checks = 0;
    n_errors = 0;
    PRESETn = 1'b1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTROBE = '0;

    // Reset state
    repeat (2) @(posedge PCLK);
    #1;
    chk("rst_prdata",  PRDATA,  32'h0);
    chk("rst_pready",  {31'b0, PREADY},  32'h0);
    chk("rst_pslverr", {31'b0, PSLVERR}, 32'h0);
    PRESETn = 1'b0;
    apb_read(6'd0,  rd, rs, ra); chk("rst_rd0",  rd, 32'h0);
    apb_read(6'd17, rd, rs, ra); chk("rst_rd17", rd, 32'h0);
    apb_read(6'd63, rd, rs, ra); chk("rst_rd63", rd, 32'h0);

    // Byte strobes
    strb_addr = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd5};
    strb_val  = '{4'h4, 4'h3, 4'h2, 4'h1, 4'hF};
    strb_exp  = '{32'h00550000, 32'h00005555, 32'h00005500, 32'h00000055, 32'h55555555};
    for (int k = 0; k < 5; k++) begin
      apb_write(strb_addr[k], 32'h55555555, strb_val[k], rs, ra, er);
      chk("strb_wr_err", {31'b0, er}, 32'h0);
    end
    for (int k = 0; k < 5; k++) begin
      apb_read(strb_addr[k], rd, rs, ra);
      chk($sformatf("strb_rd%0d", strb_addr[k]), rd, strb_exp[k]);
    end

    // Zero strobe: error, still completes, memory untouched, PRDATA holds
    apb_write(6'd4, 32'hFFFFFFFF, 4'h0, rs, ra, er);
    chk("zs_pslverr", {31'b0, er}, 32'h1);
    chk("zs_pready",  {31'b0, ra}, 32'h1);
    chk("zs_prdata_hold", PRDATA, 32'h55555555);
    apb_read(6'd4, rd, rs, ra);
    chk("zs_rd4", rd, 32'h0);

    // Abort: setup a write to addr 7, then drop PSEL
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = 6'd7; PWDATA = 32'hDEADBEEF; PSTROBE = 4'hF;
    @(posedge PCLK); #1;
    PSEL = 1'b0;
    @(posedge PCLK); #1;
    // Back in IDLE, an access-looking cycle without setup must not complete
    PSEL = 1'b1; PENABLE = 1'b1;
    @(negedge PCLK);
    chk("abort_idle_pready", {31'b0, PREADY}, 32'h0);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    apb_read(6'd7, rd, rs, ra);
    chk("abort_rd7", rd, 32'h0);

    // Sweep with back-to-back transfers
    for (int i = 0; i < 64; i++) begin
      apb_write(6'(i), 32'(i), 4'hF, rs, ra, er);
      chk($sformatf("sw_wr%0d_rdy_setup", i), {31'b0, rs}, 32'h0);
      chk($sformatf("sw_wr%0d_rdy_acc", i),   {31'b0, ra}, 32'h1);
    end
    for (int i = 0; i < 64; i++) begin
      apb_read(6'(i), rd, rs, ra);
      chk($sformatf("sw_rd%0d", i), rd, 32'(i));
      chk($sformatf("sw_rd%0d_rdy_setup", i), {31'b0, rs}, 32'h0);
      chk($sformatf("sw_rd%0d_rdy_acc", i),   {31'b0, ra}, 32'h1);
    end
    @(negedge PCLK);
    chk("sw_idle_pready", {31'b0, PREADY}, 32'h0);
    @(posedge PCLK); #1;

    // Mid-transfer reset during a write access phase
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
    PADDR = 6'd9; PWDATA = 32'hCAFEF00D; PSTROBE = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    chk("mr_pre_pready", {31'b0, PREADY}, 32'h1);
    PRESETn = 1'b1;
    #1;
    chk("mr_pready",  {31'b0, PREADY},  32'h0);
    chk("mr_prdata",  PRDATA, 32'h0);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    PRESETn = 1'b0;
    apb_read(6'd9, rd, rs, ra);
    chk("mr_rd9", rd, 32'h0);
    chk("mr_first_rdy", {31'b0, ra}, 32'h1);
    apb_read(6'd5, rd, rs, ra);  chk("mr_rd5",  rd, 32'h0);
    apb_read(6'd63, rd, rs, ra); chk("mr_rd63", rd, 32'h0);

    // Write then read same address after reset
    apb_write(6'd33, 32'h12345678, 4'hF, rs, ra, er);
    apb_read(6'd33, rd, rs, ra);
    chk("wr_rd33", rd, 32'h12345678);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
